mux_8_1_rr_v: RTL

Eight-lane round-robin collector: the gathering end of the 1:8 distribution path. Up to eight upstream lanes each present a DATA_W word with valid/ready; the block arbitrates fairly among them, registers one word per cycle, and forwards it on a single valid/ready output together with the 3-bit select code of its source lane. Downstream logic can feed that select code straight back into a 1:8 deMUX to route replies.

---
 rtl/mux_pkg_v.sv | 38 +++
 rtl/rr_arbiter_8_v.sv | 27 ++
 rtl/mux_8_1_rr_v.sv | 88 ++++++++
 3 files changed

// File: rtl/mux_pkg_v.sv
// Shared definitions for the 1:8 / 8:1 lane routing path.
package mux_pkg_v;

  localparam int unsigned N_LANES = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Index of the set bit in a one-hot vector (zero when no bit is set).
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_LANES-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (oh[k]) idx = idx | SEL_W'(k);
    end
    return idx;
  endfunction

  // Rotate right: result[i] = v[(i + sh) mod N_LANES].
  function automatic logic [N_LANES-1:0] rotate_right(input logic [N_LANES-1:0] v,
                                                      input logic [SEL_W-1:0]   sh);
    logic [2*N_LANES-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[N_LANES-1:0];
  endfunction

  // Rotate left: result[i] = v[(i - sh) mod N_LANES].
  function automatic logic [N_LANES-1:0] rotate_left(input logic [N_LANES-1:0] v,
                                                     input logic [SEL_W-1:0]   sh);
    logic [2*N_LANES-1:0] dbl;
    dbl = {v, v} << sh;
    return dbl[2*N_LANES-1:N_LANES];
  endfunction

endpackage

// File: rtl/rr_arbiter_8_v.sv
// Combinational 8-way round-robin arbiter; the lane after last_ptr has top priority.
module rr_arbiter_8_v
  import mux_pkg_v::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   last_ptr,
  input  logic               en,
  output logic [N_LANES-1:0] gnt_onehot,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [SEL_W-1:0]   start;
  logic [N_LANES-1:0] req_rot;
  logic [N_LANES-1:0] pick_rot;

  // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    start      = last_ptr + SEL_W'(1);
    req_rot    = rotate_right(req, start);
    pick_rot   = req_rot & (~req_rot + N_LANES'(1));
    gnt_onehot = en ? rotate_left(pick_rot, start) : '0;
    gnt_idx    = onehot_to_idx(gnt_onehot);
    gnt_any    = |gnt_onehot;
  end

endmodule

// File: rtl/mux_8_1_rr_v.sv
// Eight-lane round-robin collector with a registered valid/ready output stage.
module mux_8_1_rr_v
  import mux_pkg_v::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_LANES-1:0]          i_valid,
  input  logic [N_LANES*DATA_W-1:0]   i_data,
  output logic [N_LANES-1:0]          o_ready,
  output logic                        o_valid,
  output logic [DATA_W-1:0]           o_data,
  output logic [SEL_W-1:0]            o_sel_code,
  input  logic                        i_ready
);

  out_state_e          state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    last_ptr_q, last_ptr_d;

  logic                load_en;
  logic                arb_en;
  logic [N_LANES-1:0]  gnt_onehot;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [DATA_W-1:0]   lane_word;

  assign load_en = (state_q == ST_EMPTY) || i_ready;
  // Reset gates the grant so no lane sees o_ready while the stage is being cleared.
  assign arb_en  = load_en && !i_rst;

  rr_arbiter_8_v u_arb (
    .req        (i_valid),
    .last_ptr   (last_ptr_q),
    .en         (arb_en),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Register output stage state, word, source code and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      data_q     <= '0;
      sel_q      <= '0;
      last_ptr_q <= '1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Next state: load the granted word, drain to EMPTY, or hold under backpressure.
  always_comb begin
    lane_word = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (gnt_onehot[k]) lane_word = i_data[k*DATA_W +: DATA_W];
    end
    state_d    = state_q;
    data_d     = data_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    if (load_en) begin
      if (gnt_any) begin
        state_d    = ST_FULL;
        data_d     = lane_word;
        sel_d      = gnt_idx;
        last_ptr_d = gnt_idx;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Outputs: registered word plus combinational per-lane accept strobe.
  always_comb begin
    o_valid    = (state_q == ST_FULL);
    o_data     = data_q;
    o_sel_code = sel_q;
    o_ready    = gnt_onehot;
  end

endmodule
